fifo_sync_fwft: RTL and testbench

FIFO_SYNC_FWFT -- requirements
Module: fifo_sync_fwft

---
 rtl/fifo_sync_fwft_pkg.sv | 12 +
 rtl/bram_infer.sv | 33 +++
 rtl/fifo_sync_fwft.sv | 156 +++++++++++++++
 tb/tb_fifo_sync_fwft.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_fwft_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode constants and pointer sizing.
package fifo_sync_fwft_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // One address bit per doubling of depth plus a wrap bit to tell full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bram_infer.sv
// Simple dual-port inferred RAM: one write port, one read port with a registered output.
module bram_infer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array is left out of reset so it can map onto block RAM; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO over an inferred RAM, with standard or first-word-fall-through read mode.
module fifo_sync_fwft
    import fifo_sync_fwft_pkg::*;
#(
    parameter int DIN_WIDTH     = 16,
    parameter int FIFO_DEPTH    = 64,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIN_WIDTH-1:0]          wdata,
    input  logic                          w_valid,
    output logic                          full,
    output logic                          almost_full,
    output logic [DIN_WIDTH-1:0]          rdata,
    output logic                          r_valid,
    input  logic                          read_req,
    output logic                          empty,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int AW = PW - 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 rd_reject;
    logic                 ram_re;
    logic [DIN_WIDTH-1:0] ram_dout;

    assign full         = (count == CW'(FIFO_DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AFULL_THRESH));
    assign almost_empty = (count <= CW'(AEMPTY_THRESH));

    // A write while full is dropped even if a read frees a slot in the same cycle.
    assign wr_accept = w_valid && !full;

    bram_infer #(
        .DATA_WIDTH (DIN_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_dout)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Two-stage prefetch: the RAM read register (mid) feeds the output register.
            logic                 mid_valid;
            logic                 out_valid;
            logic [DIN_WIDTH-1:0] out_data;
            logic                 mid_move;
            logic                 mem_has_data;

            assign mem_has_data = (wr_ptr != rd_ptr);
            assign rd_accept    = read_req && out_valid;
            assign rd_reject    = read_req && !out_valid;
            assign mid_move     = mid_valid && (!out_valid || rd_accept);
            assign ram_re       = mem_has_data && (!mid_valid || mid_move);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mid_valid <= 1'b0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else begin
                    if (ram_re) begin
                        mid_valid <= 1'b1;
                    end else if (mid_move) begin
                        mid_valid <= 1'b0;
                    end

                    if (mid_move) begin
                        out_valid <= 1'b1;
                        out_data  <= ram_dout;
                    end else if (rd_accept) begin
                        out_valid <= 1'b0;
                    end
                end
            end

            assign r_valid = out_valid;
            assign rdata   = out_data;
        end else begin : g_std
            logic std_valid;

            assign rd_accept = read_req && !empty;
            assign rd_reject = read_req && empty;
            assign ram_re    = rd_accept;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    std_valid <= 1'b0;
                end else begin
                    std_valid <= rd_accept;
                end
            end

            // The RAM read register only loads on a read, so it holds the last word by itself.
            assign r_valid = std_valid;
            assign rdata   = ram_dout;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (w_valid && full) begin
                    overflow <= 1'b1;
                end
                if (rd_reject) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Self-checking bench: an FWFT instance and a standard-mode instance, both eight deep.
module tb_fifo_sync_fwft;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // FWFT instance, thresholds 6 / 2
    logic [15:0] f_wdata = '0;
    logic        f_w_valid = 1'b0, f_read_req = 1'b0, f_clr_err = 1'b0;
    logic        f_full, f_afull, f_r_valid, f_empty, f_aempty, f_overflow, f_underflow;
    logic [15:0] f_rdata;
    logic [3:0]  f_count;

    // standard-mode instance
    logic [15:0] s_wdata = '0;
    logic        s_w_valid = 1'b0, s_read_req = 1'b0, s_clr_err = 1'b0;
    logic        s_full, s_afull, s_r_valid, s_empty, s_aempty, s_overflow, s_underflow;
    logic [15:0] s_rdata;
    logic [3:0]  s_count;

    fifo_sync_fwft #(.DIN_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) dut_f (
        .clk(clk), .rst(rst), .wdata(f_wdata), .w_valid(f_w_valid), .full(f_full),
        .almost_full(f_afull), .rdata(f_rdata), .r_valid(f_r_valid), .read_req(f_read_req),
        .empty(f_empty), .almost_empty(f_aempty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow), .clr_err(f_clr_err)
    );

    fifo_sync_fwft #(.DIN_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) dut_s (
        .clk(clk), .rst(rst), .wdata(s_wdata), .w_valid(s_w_valid), .full(s_full),
        .almost_full(s_afull), .rdata(s_rdata), .r_valid(s_r_valid), .read_req(s_read_req),
        .empty(s_empty), .almost_empty(s_aempty), .count(s_count), .overflow(s_overflow),
        .underflow(s_underflow), .clr_err(s_clr_err)
    );

    typedef struct {
        logic [15:0] wdata;
        logic [3:0]  count;
        logic        full;
        logic        afull;
        logic        aempty;
        logic        empty;
    } vec_t;

    vec_t        vecs [9];
    logic [15:0] sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_f(input string tag);
        check({tag, "_count"},  f_count, 0);
        check({tag, "_empty"},  f_empty, 1);
        check({tag, "_aempty"}, f_aempty, 1);
        check({tag, "_full"},   f_full, 0);
        check({tag, "_afull"},  f_afull, 0);
        check({tag, "_rvalid"}, f_r_valid, 0);
        check({tag, "_rdata"},  f_rdata, 0);
        check({tag, "_ovf"},    f_overflow, 0);
        check({tag, "_unf"},    f_underflow, 0);
    endtask

    task automatic wait_rvalid(input string name);
        int c = 0;
        while (!f_r_valid && c < 10) begin
            step();
            c++;
        end
        check(name, f_r_valid, 1);
    endtask

    // Consume n words from the FWFT instance, comparing against the scoreboard.
    task automatic drain(input int n, output int cycles);
        int got = 0;
        cycles = 0;
        while (got < n && cycles < 200) begin
            if (f_r_valid) begin
                if (sb.size() == 0) begin
                    check("drain_unexpected", f_rdata, 32'hdead_beef);
                end else begin
                    check("drain_data", f_rdata, sb.pop_front());
                end
                got++;
                f_read_req = 1'b1;
            end else begin
                f_read_req = 1'b0;
            end
            step();
            cycles++;
        end
        f_read_req = 1'b0;
        if (got < n) check("drain_timeout", got, n);
    endtask

    task automatic write_words(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            f_w_valid = 1'b1;
            f_wdata   = base + 16'(i);
            sb.push_back(f_wdata);
            step();
        end
        f_w_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        vecs[0] = '{16'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'd2, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'd6, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'd7, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'd8, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'd9, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0};

        #1;
        check_reset_f("rst0");
        check("rst0_s_empty", s_empty, 1);
        check("rst0_s_rdata", s_rdata, 0);
        #11 rst = 1'b1;
        step();

        // Fill to full and one past it; flags from the threshold table.
        for (int i = 0; i < 9; i++) begin
            f_w_valid = 1'b1;
            f_wdata   = vecs[i].wdata;
            if (i < 8) sb.push_back(vecs[i].wdata);
            step();
            check($sformatf("fill%0d_count", i),  f_count,  vecs[i].count);
            check($sformatf("fill%0d_full", i),   f_full,   vecs[i].full);
            check($sformatf("fill%0d_afull", i),  f_afull,  vecs[i].afull);
            check($sformatf("fill%0d_aempty", i), f_aempty, vecs[i].aempty);
            check($sformatf("fill%0d_empty", i),  f_empty,  vecs[i].empty);
        end
        f_w_valid = 1'b0;
        check("overflow_set", f_overflow, 1);
        check("head_fell_through", f_rdata, 16'd1);

        drain(8, cyc);
        check("drain8_no_bubble", cyc, 8);
        check("drain8_empty", f_empty, 1);
        check("drain8_rvalid", f_r_valid, 0);
        check("overflow_sticky", f_overflow, 1);

        f_clr_err = 1'b1;
        step();
        f_clr_err = 1'b0;
        check("overflow_cleared", f_overflow, 0);

        // Single word into an empty FIFO: visible two edges after the write.
        f_w_valid = 1'b1;
        f_wdata   = 16'hABCD;
        step();
        f_w_valid = 1'b0;
        check("lat_n0_rvalid", f_r_valid, 0);
        check("lat_n0_count", f_count, 1);
        step();
        check("lat_n1_rvalid", f_r_valid, 0);
        step();
        check("lat_n2_rvalid", f_r_valid, 1);
        check("lat_n2_rdata", f_rdata, 16'hABCD);
        f_read_req = 1'b1;
        step();
        f_read_req = 1'b0;
        check("lat_n3_rvalid", f_r_valid, 0);
        check("lat_n3_empty", f_empty, 1);

        // Read with nothing to consume.
        f_read_req = 1'b1;
        step();
        f_read_req = 1'b0;
        check("f_underflow_set", f_underflow, 1);
        check("f_underflow_count", f_count, 0);
        f_clr_err = 1'b1;
        step();
        f_clr_err = 1'b0;

        // Four stored, then simultaneous write+read for 20 cycles across the wrap.
        write_words(16'h0100, 4);
        wait_rvalid("steady_prefill");
        for (int i = 0; i < 20; i++) begin
            check($sformatf("steady%0d_rvalid", i), f_r_valid, 1);
            check($sformatf("steady%0d_count", i), f_count, 4);
            if (sb.size() != 0) check($sformatf("steady%0d_data", i), f_rdata, sb.pop_front());
            f_w_valid  = 1'b1;
            f_wdata    = 16'h0104 + 16'(i);
            f_read_req = 1'b1;
            sb.push_back(f_wdata);
            step();
        end
        f_w_valid  = 1'b0;
        f_read_req = 1'b0;
        check("steady_end_count", f_count, 4);
        drain(4, cyc);
        check("steady_drained", f_empty, 1);

        // Reset while half full and mid-read; set underflow first so reset has something to clear.
        f_read_req = 1'b1;
        step();
        f_read_req = 1'b0;
        write_words(16'h0010, 4);
        wait_rvalid("rst_prefill");
        check("rst_pre_unf", f_underflow, 1);
        check("rst_pre_head", f_rdata, sb.pop_front());
        f_read_req = 1'b1;
        step();
        #2 rst = 1'b0;
        #1;
        check_reset_f("rst1");
        sb.delete();
        f_read_req = 1'b0;
        #3 rst = 1'b1;
        step();
        write_words(16'h0055, 1);
        drain(1, cyc);
        check("post_rst_empty", f_empty, 1);

        // Standard mode.
        s_read_req = 1'b1;
        step();
        check("s_unf_rvalid", s_r_valid, 0);
        check("s_unf_set", s_underflow, 1);
        check("s_unf_count", s_count, 0);
        s_clr_err = 1'b1;
        step();
        check("s_clr_priority", s_underflow, 0);
        s_read_req = 1'b0;
        s_clr_err  = 1'b0;
        s_w_valid  = 1'b1;
        s_wdata    = 16'h1234;
        step();
        s_wdata    = 16'h5678;
        step();
        s_w_valid  = 1'b0;
        check("s_count2", s_count, 2);
        check("s_no_fwft", s_r_valid, 0);
        s_read_req = 1'b1;
        step();
        s_read_req = 1'b0;
        check("s_rd1_rvalid", s_r_valid, 1);
        check("s_rd1_data", s_rdata, 16'h1234);
        check("s_rd1_count", s_count, 1);
        step();
        check("s_hold_rvalid", s_r_valid, 0);
        check("s_hold_data", s_rdata, 16'h1234);
        s_read_req = 1'b1;
        step();
        s_read_req = 1'b0;
        check("s_rd2_data", s_rdata, 16'h5678);
        check("s_rd2_empty", s_empty, 1);
        check("s_no_unf", s_underflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
